// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single memory port; exec -> MEM_exec in 1 cycle, MEM_data_ready -> completion on the same edge.
// Backpressure: O_reqN_ready is low while that slot is pending (extra pulses dropped); MEM_ready=0 holds off issue.
module mem_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 255
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_req0_exec,
    input  logic        I_req0_write,
    input  logic [15:0] I_req0_addr,
    input  logic [15:0] I_req0_data,
    output logic        O_req0_ready,
    output logic [15:0] O_req0_data,
    output logic        O_req0_data_ready,
    output logic        O_req0_error,
    input  logic        I_req1_exec,
    input  logic        I_req1_write,
    input  logic [15:0] I_req1_addr,
    input  logic [15:0] I_req1_data,
    output logic        O_req1_ready,
    output logic [15:0] O_req1_data,
    output logic        O_req1_data_ready,
    output logic        O_req1_error,
    input  logic        MEM_ready,
    output logic        MEM_exec,
    output logic        MEM_write,
    output logic [15:0] MEM_addr,
    output logic [15:0] MEM_data_out,
    input  logic [15:0] MEM_data_in,
    input  logic        MEM_data_ready
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] data;
    } slot_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  slot_free;
    slot_t       slot [2];
    slot_t       req_in [2];
    logic [1:0]  req_exec;
    logic [1:0]  pend;
    logic        gnt;
    logic        last_grant;
    logic [7:0]  tcnt;
    logic        sel;
    logic        do_issue;
    logic        do_done;
    logic        do_tout;

    assign req_exec  = {I_req1_exec, I_req0_exec};
    assign req_in[0] = {I_req0_write, I_req0_addr, I_req0_data};
    assign req_in[1] = {I_req1_write, I_req1_addr, I_req1_data};
    assign pend      = ~slot_free;

    // Ready flags are the slot-free flops themselves, so the outputs stay registered.
    assign O_req0_ready = slot_free[0];
    assign O_req1_ready = slot_free[1];

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_issue) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (do_done || do_tout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel = 1'b0;
        if (PRIORITY_MODE != 0) begin
            sel = ~pend[0];
        end else if (&pend) begin
            sel = ~last_grant;
        end else begin
            sel = pend[1];
        end
        do_issue = (state == IDLE) && (|pend) && MEM_ready;
        do_done  = (state == WAIT) && MEM_data_ready;
        // Completion wins over a timeout landing on the same edge.
        do_tout  = (state == WAIT) && !MEM_data_ready && (TIMEOUT_CNT != 8'd0) && (tcnt == TIMEOUT_CNT);
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            slot_free         <= 2'b11;
            slot[0]           <= '0;
            slot[1]           <= '0;
            gnt               <= 1'b0;
            last_grant        <= 1'b1;
            tcnt              <= 8'd0;
            MEM_exec          <= 1'b0;
            MEM_write         <= 1'b0;
            MEM_addr          <= 16'd0;
            MEM_data_out      <= 16'd0;
            O_req0_data       <= 16'd0;
            O_req1_data       <= 16'd0;
            O_req0_data_ready <= 1'b0;
            O_req1_data_ready <= 1'b0;
            O_req0_error      <= 1'b0;
            O_req1_error      <= 1'b0;
        end else begin
            MEM_exec          <= do_issue;
            O_req0_data_ready <= do_done && !gnt;
            O_req1_data_ready <= do_done && gnt;
            O_req0_error      <= do_tout && !gnt;
            O_req1_error      <= do_tout && gnt;

            if (do_issue) begin
                gnt        <= sel;
                last_grant <= sel;
                {MEM_write, MEM_addr, MEM_data_out} <= slot[sel];
            end

            if (state == ISSUE) begin
                tcnt <= 8'd0;
            end else if (state == WAIT) begin
                tcnt <= tcnt + 8'd1;
            end

            // MEM_write still describes the in-flight command, so writes leave read data alone.
            if (do_done && !MEM_write) begin
                if (gnt) begin
                    O_req1_data <= MEM_data_in;
                end else begin
                    O_req0_data <= MEM_data_in;
                end
            end

            for (int n = 0; n < 2; n++) begin
                if ((do_done || do_tout) && (gnt == 1'(n))) begin
                    slot_free[n] <= 1'b1;
                end else if (req_exec[n] && slot_free[n]) begin
                    slot_free[n] <= 1'b0;
                    slot[n]      <= req_in[n];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level reference model.
// Instance 0 is round-robin with TIMEOUT=4, instance 1 is fixed priority with the timeout disabled.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_exec  [2][2];
    logic        req_write [2][2];
    logic [15:0] req_addr  [2][2];
    logic [15:0] req_data  [2][2];
    logic        mem_ready [2];
    logic        mem_dr    [2];
    logic [15:0] mem_din   [2];
    logic        o_ready   [2][2];
    logic        o_drdy    [2][2];
    logic        o_err     [2][2];
    logic [15:0] o_data    [2][2];
    logic        m_exec    [2];
    logic        m_write   [2];
    logic [15:0] m_addr    [2];
    logic [15:0] m_dout    [2];

    mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(4)) dut0 (
        .I_clk(clk), .I_reset(rst),
        .I_req0_exec(req_exec[0][0]), .I_req0_write(req_write[0][0]),
        .I_req0_addr(req_addr[0][0]), .I_req0_data(req_data[0][0]),
        .O_req0_ready(o_ready[0][0]), .O_req0_data(o_data[0][0]),
        .O_req0_data_ready(o_drdy[0][0]), .O_req0_error(o_err[0][0]),
        .I_req1_exec(req_exec[0][1]), .I_req1_write(req_write[0][1]),
        .I_req1_addr(req_addr[0][1]), .I_req1_data(req_data[0][1]),
        .O_req1_ready(o_ready[0][1]), .O_req1_data(o_data[0][1]),
        .O_req1_data_ready(o_drdy[0][1]), .O_req1_error(o_err[0][1]),
        .MEM_ready(mem_ready[0]), .MEM_exec(m_exec[0]), .MEM_write(m_write[0]),
        .MEM_addr(m_addr[0]), .MEM_data_out(m_dout[0]),
        .MEM_data_in(mem_din[0]), .MEM_data_ready(mem_dr[0])
    );

    mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(0)) dut1 (
        .I_clk(clk), .I_reset(rst),
        .I_req0_exec(req_exec[1][0]), .I_req0_write(req_write[1][0]),
        .I_req0_addr(req_addr[1][0]), .I_req0_data(req_data[1][0]),
        .O_req0_ready(o_ready[1][0]), .O_req0_data(o_data[1][0]),
        .O_req0_data_ready(o_drdy[1][0]), .O_req0_error(o_err[1][0]),
        .I_req1_exec(req_exec[1][1]), .I_req1_write(req_write[1][1]),
        .I_req1_addr(req_addr[1][1]), .I_req1_data(req_data[1][1]),
        .O_req1_ready(o_ready[1][1]), .O_req1_data(o_data[1][1]),
        .O_req1_data_ready(o_drdy[1][1]), .O_req1_error(o_err[1][1]),
        .MEM_ready(mem_ready[1]), .MEM_exec(m_exec[1]), .MEM_write(m_write[1]),
        .MEM_addr(m_addr[1]), .MEM_data_out(m_dout[1]),
        .MEM_data_in(mem_din[1]), .MEM_data_ready(mem_dr[1])
    );

    // Reference model: per-requester request slots plus one in-flight transaction tracked by its age in cycles.
    bit          pend   [2][2];
    bit          sw     [2][2];
    logic [15:0] sa     [2][2];
    logic [15:0] sd     [2][2];
    bit          active [2];
    int          gnt    [2];
    int          age    [2];
    int          last   [2];
    logic        e_mexec  [2];
    logic        e_mwrite [2];
    logic [15:0] e_maddr  [2];
    logic [15:0] e_mdout  [2];
    logic [15:0] e_data   [2][2];
    logic        e_drdy   [2][2];
    logic        e_err    [2][2];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    function automatic int tmo(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(int d);
        bit p [2];
        int g;
        p[0] = pend[d][0];
        p[1] = pend[d][1];
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                pend[d][n] = 0; e_data[d][n] = 16'd0; e_drdy[d][n] = 1'b0; e_err[d][n] = 1'b0;
            end
            active[d] = 0; age[d] = 0; last[d] = 1;
            e_mexec[d] = 1'b0; e_mwrite[d] = 1'b0; e_maddr[d] = 16'd0; e_mdout[d] = 16'd0;
            return;
        end
        e_mexec[d] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            e_drdy[d][n] = 1'b0; e_err[d][n] = 1'b0;
        end
        if (active[d]) begin
            age[d]++;
            g = gnt[d];
            // Age 1 is the command cycle itself; the response window opens at age 2 with the wait count at 0.
            if (age[d] >= 2 && mem_dr[d] === 1'b1) begin
                if (!sw[d][g]) e_data[d][g] = mem_din[d];
                e_drdy[d][g] = 1'b1; pend[d][g] = 0; active[d] = 0;
            end else if (age[d] >= 2 && tmo(d) != 0 && age[d] - 2 == tmo(d)) begin
                e_err[d][g] = 1'b1; pend[d][g] = 0; active[d] = 0;
            end
        end else if ((p[0] || p[1]) && mem_ready[d] === 1'b1) begin
            if (p[0] && p[1]) g = (d == 1) ? 0 : 1 - last[d];
            else g = p[0] ? 0 : 1;
            active[d] = 1; age[d] = 0; gnt[d] = g; last[d] = g;
            e_mexec[d] = 1'b1; e_mwrite[d] = sw[d][g]; e_maddr[d] = sa[d][g]; e_mdout[d] = sd[d][g];
        end
        for (int n = 0; n < 2; n++) begin
            if (req_exec[d][n] === 1'b1 && !p[n]) begin
                pend[d][n] = 1; sw[d][n] = req_write[d][n]; sa[d][n] = req_addr[d][n]; sd[d][n] = req_data[d][n];
            end
        end
    endtask

    task automatic check_dut(int d);
        chk($sformatf("d%0d_mem_exec", d), 32'(m_exec[d]), 32'(e_mexec[d]));
        chk($sformatf("d%0d_mem_write", d), 32'(m_write[d]), 32'(e_mwrite[d]));
        chk($sformatf("d%0d_mem_addr", d), 32'(m_addr[d]), 32'(e_maddr[d]));
        chk($sformatf("d%0d_mem_data_out", d), 32'(m_dout[d]), 32'(e_mdout[d]));
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("d%0d_req%0d_ready", d, n), 32'(o_ready[d][n]), 32'(!pend[d][n]));
            chk($sformatf("d%0d_req%0d_data", d, n), 32'(o_data[d][n]), 32'(e_data[d][n]));
            chk($sformatf("d%0d_req%0d_data_ready", d, n), 32'(o_drdy[d][n]), 32'(e_drdy[d][n]));
            chk($sformatf("d%0d_req%0d_error", d, n), 32'(o_err[d][n]), 32'(e_err[d][n]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0);
        check_dut(1);
        for (int d = 0; d < 2; d++) begin
            mem_dr[d] = 1'b0;
            for (int n = 0; n < 2; n++) req_exec[d][n] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(int d, int n, logic w, logic [15:0] a, logic [15:0] dat);
        req_exec[d][n] = 1'b1; req_write[d][n] = w; req_addr[d][n] = a; req_data[d][n] = dat;
    endtask

    // Waits (bounded) for a command, answers it lat cycles after the strobe, then completes it.
    task automatic run_txn(int d, int lat, logic [15:0] rdata,
                           output logic [15:0] a, output logic w, output logic [15:0] dv);
        int n = 0;
        a = 16'd0; w = 1'b0; dv = 16'd0;
        while (m_exec[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("d%0d_issue_seen", d), 32'(m_exec[d]), 32'd1);
        if (m_exec[d] === 1'b1) begin
            a = m_addr[d]; w = m_write[d]; dv = m_dout[d];
            repeat (lat) tick();
            mem_dr[d] = 1'b1; mem_din[d] = rdata;
            tick();
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] dv;
        logic        w;
        int          k;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mem_ready[d] = 1'b1; mem_dr[d] = 1'b0; mem_din[d] = 16'd0;
            for (int n = 0; n < 2; n++) begin
                req_exec[d][n] = 1'b0; req_write[d][n] = 1'b0; req_addr[d][n] = 16'd0; req_data[d][n] = 16'd0;
            end
        end
        do_reset();
        chk("reset_req0_ready", 32'(o_ready[0][0]), 32'd1);
        chk("reset_mem_exec", 32'(m_exec[0]), 32'd0);

        // Single read
        pulse(0, 0, 1'b0, 16'h0010, 16'h0);
        tick();
        chk("rd_ready_low", 32'(o_ready[0][0]), 32'd0);
        tick();
        chk("rd_exec", 32'(m_exec[0]), 32'd1);
        chk("rd_addr", 32'(m_addr[0]), 32'h0010);
        chk("rd_write", 32'(m_write[0]), 32'd0);
        tick();
        chk("rd_exec_drop", 32'(m_exec[0]), 32'd0);
        tick();
        mem_dr[0] = 1'b1; mem_din[0] = 16'hBEEF;
        tick();
        chk("rd_data_ready", 32'(o_drdy[0][0]), 32'd1);
        chk("rd_data", 32'(o_data[0][0]), 32'hBEEF);
        chk("rd_ready_back", 32'(o_ready[0][0]), 32'd1);
        tick();
        chk("rd_data_ready_pulse", 32'(o_drdy[0][0]), 32'd0);

        // Round-robin contention
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse(0, 0, 1'b0, 16'(16'h0100 + i), 16'h0);
            if (i == 0) pulse(0, 1, 1'b1, 16'h0020, 16'h1234);
            else pulse(0, 1, 1'b0, 16'(16'h0200 + i), 16'h0);
            tick();
            run_txn(0, 1, 16'(16'hC000 + i), a, w, dv);
            chk("rr_first_grant", 32'(a), 32'(16'h0100 + i));
            run_txn(0, 1, 16'(16'hD000 + i), a, w, dv);
            chk("rr_second_grant", 32'(a), (i == 0) ? 32'h0020 : 32'(16'h0200 + i));
            if (i == 0) begin
                chk("rr_write_flag", 32'(w), 32'd1);
                chk("rr_write_data", 32'(dv), 32'h1234);
            end
        end

        // Fixed priority with requester 0 re-requesting after each completion
        do_reset();
        pulse(1, 1, 1'b0, 16'h0300, 16'h0);
        pulse(1, 0, 1'b0, 16'h0400, 16'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            run_txn(1, (i == 2) ? 12 : 1, 16'(16'hE000 + i), a, w, dv);
            chk("fp_req0_wins", 32'(a), 32'(16'h0400 + i));
            chk("fp_req0_done", 32'(o_drdy[1][0]), 32'd1);
            mem_ready[1] = 1'b0;
            if (i < 3) pulse(1, 0, 1'b0, 16'(16'h0401 + i), 16'h0);
            tick();
            mem_ready[1] = 1'b1;
        end
        run_txn(1, 1, 16'hF00D, a, w, dv);
        chk("fp_req1_last", 32'(a), 32'h0300);

        // Timeout, then the other pending request issues
        do_reset();
        pulse(0, 0, 1'b0, 16'h0500, 16'h0);
        pulse(0, 1, 1'b0, 16'h0600, 16'h0);
        tick();
        tick();
        chk("to_exec", 32'(m_exec[0]), 32'd1);
        k = 0;
        while (o_err[0][0] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("to_cycles", 32'(k), 32'd6);
        chk("to_ready", 32'(o_ready[0][0]), 32'd1);
        chk("to_no_done", 32'(o_drdy[0][0]), 32'd0);
        tick();
        chk("to_next_exec", 32'(m_exec[0]), 32'd1);
        chk("to_next_addr", 32'(m_addr[0]), 32'h0600);
        run_txn(0, 1, 16'h0BAD, a, w, dv);
        // Response arriving on the timeout edge counts as completion
        pulse(0, 0, 1'b0, 16'h0510, 16'h0);
        tick();
        run_txn(0, 5, 16'hA5A5, a, w, dv);
        chk("to_tie_done", 32'(o_drdy[0][0]), 32'd1);
        chk("to_tie_no_err", 32'(o_err[0][0]), 32'd0);
        chk("to_tie_data", 32'(o_data[0][0]), 32'hA5A5);

        // Busy memory and a dropped duplicate request
        do_reset();
        mem_ready[0] = 1'b0;
        pulse(0, 0, 1'b1, 16'h0700, 16'h5555);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) pulse(0, 0, 1'b0, 16'h0777, 16'h0);
            tick();
            chk("busy_no_exec", 32'(m_exec[0]), 32'd0);
        end
        mem_ready[0] = 1'b1;
        run_txn(0, 2, 16'h9999, a, w, dv);
        chk("busy_addr", 32'(a), 32'h0700);
        chk("busy_write", 32'(w), 32'd1);
        chk("busy_wdata", 32'(dv), 32'h5555);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_exec[0] === 1'b1) k++;
        end
        chk("busy_single_txn", 32'(k), 32'd0);

        // Reset while waiting for memory
        pulse(0, 0, 1'b0, 16'h0800, 16'h0);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_exec", 32'(m_exec[0]), 32'd0);
        chk("rw_addr", 32'(m_addr[0]), 32'd0);
        chk("rw_ready0", 32'(o_ready[0][0]), 32'd1);
        chk("rw_ready1", 32'(o_ready[0][1]), 32'd1);
        mem_dr[0] = 1'b1; mem_din[0] = 16'h1111;
        tick();
        chk("rw_no_done", 32'(o_drdy[0][0]), 32'd0);
        chk("rw_data", 32'(o_data[0][0]), 32'd0);

        // Random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                mem_ready[d] = ($urandom_range(0, 3) != 0);
                mem_dr[d]    = ($urandom_range(0, 3) == 0);
                mem_din[d]   = 16'($urandom);
                for (int n = 0; n < 2; n++) begin
                    req_exec[d][n]  = ($urandom_range(0, 2) == 0);
                    req_write[d][n] = 1'($urandom);
                    req_addr[d][n]  = 16'($urandom);
                    req_data[d][n]  = 16'($urandom);
                end
            end
            tick();
        end
        rst = 1'b0;
        mem_ready[0] = 1'b1;
        mem_ready[1] = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority with requester 0 winning.
- TIMEOUT, 255, WAIT-state cycle limit (8-bit); 0 = timeout disabled.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- I_clk, in, 1, single clock; all logic on the rising edge.
- I_reset, in, 1, synchronous, active-high reset.
- I_reqN_exec, in, 1, (N=0,1) one-cycle request pulse.
- I_reqN_write, in, 1, 1 = write, 0 = read.
- I_reqN_addr, in, 16, address.
- I_reqN_data, in, 16, write data.
- O_reqN_ready, out, 1, requester N may issue a request.
- O_reqN_data, out, 16, read data.
- O_reqN_data_ready, out, 1, one-cycle completion pulse.
- O_reqN_error, out, 1, one-cycle timeout pulse.
- MEM_ready, in, 1, memory can accept a command.
- MEM_exec, out, 1, one-cycle command strobe.
- MEM_write, out, 1, command is a write.
- MEM_addr, out, 16, command address.
- MEM_data_out, out, 16, write data to memory.
- MEM_data_in, in, 16, read data from memory.
- MEM_data_ready, in, 1, memory completion pulse.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 Each requester SHALL have one pending slot latching exec/write/addr/data.
REQ-005 O_reqN_ready SHALL equal NOT pendingN.
REQ-006 An I_reqN_exec pulse sampled while O_reqN_ready=1 SHALL set pendingN at that edge; a pulse while O_reqN_ready=0 SHALL be ignored (no state change).
REQ-007 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
REQ-008 IDLE with any pending and MEM_ready=1 SHALL select a grant, load MEM_write/MEM_addr/MEM_data_out from that slot, set MEM_exec=1, and go to ISSUE.
REQ-009 IDLE with MEM_ready=0 SHALL hold IDLE, MEM_exec=0.
REQ-010 ISSUE SHALL last exactly one cycle, clear MEM_exec, and go to WAIT.
REQ-011 MEM_addr, MEM_write and MEM_data_out SHALL hold stable through ISSUE and WAIT.
REQ-012 In WAIT, MEM_data_ready=1 SHALL perform all of the following at that edge:
- capture MEM_data_in into O_reqG_data (G = granted requester);
- pulse O_reqG_data_ready for one cycle; write completions also pulse it, with O_reqG_data unchanged;
- clear pendingG;
- return to IDLE.
REQ-013 MEM_data_ready in IDLE or ISSUE SHALL be ignored.
REQ-014 Minimum latency SHALL be as follows:
- exec sampled at edge k gives MEM_exec=1 after edge k+1;
- MEM_data_ready sampled at edge m gives O_data_ready=1 and O_ready=1 after edge m.
REQ-015 Round-robin SHALL work as follows:
- with both pending, grant the requester not granted last;
- with one pending, grant it;
- last_grant updates on every grant.
REQ-016 Fixed priority SHALL grant requester 0 whenever pending0=1.
REQ-017 The timeout counter SHALL be 8-bit, cleared on WAIT entry and incremented each WAIT cycle.
REQ-018 When the counter equals TIMEOUT (TIMEOUT≠0) without MEM_data_ready, the block SHALL pulse O_reqG_error for one cycle, leave O_reqG_data unchanged, clear pendingG, and return to IDLE.
REQ-019 MEM_data_ready and timeout on the same edge SHALL resolve as completion, with no error pulse.
REQ-020 A request from the requester completing on the same edge SHALL be ignored, because O_ready was 0 at that edge.
REQ-021 A request from the other requester SHALL be accepted in any state and served after the current transaction.
REQ-022 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-023 I_reset=1 at an edge SHALL force all of the following, regardless of state:
- FSM = IDLE;
- pending0 = pending1 = 0;
- last_grant = 1, so requester 0 wins the first tie;
- timeout counter = 0;
- MEM_exec = MEM_write = 0; MEM_addr = MEM_data_out = 0;
- O_reqN_data = 0; O_reqN_data_ready = O_reqN_error = 0; O_reqN_ready = 1.
REQ-024 Reset mid-transaction SHALL abandon it with no completion or error pulse; a later MEM_data_ready SHALL be ignored.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single read: req0 read addr 0x0010 at edge k; MEM_ready=1; MEM_data_ready with 0xBEEF 3 cycles after MEM_exec -> MEM_exec one cycle after edge k+1 with MEM_addr=0x0010, MEM_write=0; O_req0_data=0xBEEF with a one-cycle O_req0_data_ready; O_req0_ready back to 1.
- Round-robin contention: both requesters pulse the same cycle, repeated 4 times, PRIORITY_MODE=0 -> grant order 0,1,0,1; write 0x1234 to 0x0020 from req1 shows MEM_write=1, MEM_data_out=0x1234.
- Fixed priority: PRIORITY_MODE=1, req1 pending, req0 re-requests every completion -> req1 is never granted while pending0=1.
- Timeout: TIMEOUT=4, no MEM_data_ready -> O_req0_error pulses after 4 WAIT cycles, pending0 cleared, then the next pending request issues.
- Busy memory and dropped request: MEM_ready=0 for 5 cycles -> no MEM_exec during that time; a second req0 pulse while O_req0_ready=0 is dropped, so exactly one transaction occurs.
- Reset in WAIT: assert I_reset -> all outputs take reset values next cycle; a subsequent MEM_data_ready produces no O_data_ready pulse.
